pe_traffic_gen: RTL



---
 rtl/pe_traffic_gen.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/pe_traffic_gen.sv
// rtl/pe_traffic_gen.sv - mesh node PE traffic engine driving the NIC CPU port
// Alternates one tx attempt and one rx attempt per pass; injects NUM_PACKETS addressed packets.
module pe_traffic_gen #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_PACKETS  = 8,
    parameter int MESH_DIM     = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [3:0]              node_pos,
    output logic [1:0]              addr,
    output logic [PACKET_WIDTH-1:0] d_in,
    input  logic [PACKET_WIDTH-1:0] d_out,
    output logic                    nicEn,
    output logic                    nicEnWR,
    output logic [7:0]              tx_count,
    output logic [7:0]              rx_count,
    output logic [7:0]              err_count,
    output logic                    done
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TX_POLL  = 3'd1;
    localparam logic [2:0] TX_WAIT  = 3'd2;
    localparam logic [2:0] TX_WRITE = 3'd3;
    localparam logic [2:0] RX_POLL  = 3'd4;
    localparam logic [2:0] RX_WAIT  = 3'd5;
    localparam logic [2:0] RX_READ  = 3'd6;
    localparam logic [2:0] RX_CHECK = 3'd7;

    localparam logic [9:0] NODES   = 10'(MESH_DIM * MESH_DIM);
    localparam logic [9:0] DIM     = 10'(MESH_DIM);
    localparam logic [7:0] NUM_PKT = 8'(NUM_PACKETS);

    logic [2:0]              state_q, state_d;
    logic                    strobe_q, strobe_d;
    logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
    logic [7:0]              tx_count_q, tx_count_d;
    logic [7:0]              rx_count_q, rx_count_d;
    logic [7:0]              err_count_q, err_count_d;
    logic                    done_q, done_d;

    logic                    strobe_state, access;
    logic [1:0]              own_row, own_col, dest_row, dest_col, dx, dy;
    logic [9:0]              node_idx, sum_idx, dest_idx;
    logic [PACKET_WIDTH-1:0] pkt_next;
    logic                    unused_d_out;

    // Destination walks the mesh from this node, skipping itself.
    always_comb begin
        own_row  = node_pos[3:2];
        own_col  = node_pos[1:0];
        node_idx = {8'd0, own_row} * DIM + {8'd0, own_col};
        sum_idx  = (node_idx + {2'd0, tx_count_q} + 10'd1) % NODES;
        dest_idx = (sum_idx == node_idx) ? (sum_idx + 10'd1) % NODES : sum_idx;
        dest_row = 2'(dest_idx / DIM);
        dest_col = 2'(dest_idx % DIM);
        dx       = (dest_col > own_col) ? dest_col - own_col : own_col - dest_col;
        dy       = (dest_row > own_row) ? dest_row - own_row : own_row - dest_row;
        pkt_next          = '0;
        pkt_next[62]      = dest_col < own_col;
        pkt_next[61]      = dest_row < own_row;
        pkt_next[55:52]   = {2'b00, dx};
        pkt_next[51:48]   = {2'b00, dy};
        pkt_next[43:40]   = node_pos;
        pkt_next[39:36]   = {dest_row, dest_col};
        pkt_next[7:0]     = tx_count_q;
    end

    // An access state stalls one cycle if the previous cycle already strobed (TX_WRITE -> RX_POLL).
    assign strobe_state = (state_q == TX_POLL) || (state_q == TX_WRITE) ||
                          (state_q == RX_POLL) || (state_q == RX_READ);
    assign access       = strobe_state && !strobe_q;

    always_comb begin
        state_d     = state_q;
        strobe_d    = access;
        pkt_d       = pkt_q;
        tx_count_d  = tx_count_q;
        rx_count_d  = rx_count_q;
        err_count_d = err_count_q;
        done_d      = done_q;
        case (state_q)
            IDLE: begin
                if (enable) state_d = done_q ? RX_POLL : TX_POLL;
            end
            TX_POLL: begin
                if (access) state_d = TX_WAIT;
            end
            TX_WAIT: begin
                if (d_out[0]) begin
                    state_d = RX_POLL;
                end else begin
                    pkt_d   = pkt_next;
                    state_d = TX_WRITE;
                end
            end
            TX_WRITE: begin
                if (access) begin
                    tx_count_d = tx_count_q + 8'd1;
                    if (tx_count_q + 8'd1 == NUM_PKT) done_d = 1'b1;
                    state_d = RX_POLL;
                end
            end
            RX_POLL: begin
                if (access) state_d = RX_WAIT;
            end
            RX_WAIT: begin
                state_d = d_out[0] ? RX_READ : IDLE;
            end
            RX_READ: begin
                if (access) state_d = RX_CHECK;
            end
            default: begin
                if (rx_count_q != 8'hFF) rx_count_d = rx_count_q + 8'd1;
                if (d_out[39:36] != node_pos && err_count_q != 8'hFF)
                    err_count_d = err_count_q + 8'd1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            strobe_q    <= 1'b0;
            pkt_q       <= '0;
            tx_count_q  <= 8'd0;
            rx_count_q  <= 8'd0;
            err_count_q <= 8'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            strobe_q    <= strobe_d;
            pkt_q       <= pkt_d;
            tx_count_q  <= tx_count_d;
            rx_count_q  <= rx_count_d;
            err_count_q <= err_count_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        addr = 2'b00;
        if (access) begin
            case (state_q)
                TX_POLL:  addr = 2'b11;
                TX_WRITE: addr = 2'b10;
                RX_POLL:  addr = 2'b01;
                default:  addr = 2'b00;
            endcase
        end
    end

    assign nicEn     = access;
    assign nicEnWR   = access && (state_q == TX_WRITE);
    assign d_in      = nicEnWR ? pkt_q : '0;
    assign tx_count  = tx_count_q;
    assign rx_count  = rx_count_q;
    assign err_count = err_count_q;
    assign done      = done_q;

    assign unused_d_out = ^{d_out[PACKET_WIDTH-1:40], d_out[35:1]};

endmodule
